// File: rtl/fifo_word_to_uart.sv
// Drains DATA_W-bit words from a 1-cycle-latency FIFO and serialises each one
// into bytes on a valid/ready UART TX port, with an optional sync header byte.
// Ports: clk, rstn (sync, active-low), enable (permit reads),
//   fifo_dout/fifo_empty/fifo_rd_en (FIFO side),
//   uart_data/uart_valid/uart_ready (byte side),
//   busy (word in flight), words_sent (completed words, wraps).
module fifo_word_to_uart #(
  parameter int unsigned DATA_W    = 32,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned FRAME_LEN = 0,
  parameter logic [7:0]  HEADER    = 8'hA5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [7:0]        uart_data,
  output logic              uart_valid,
  input  logic              uart_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned IDX_W  =
    (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned FC_W   =
    (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NBYTES - 1);
  localparam logic [FC_W-1:0] LAST_FC =
    FC_W'((FRAME_LEN == 0) ? 0 : FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    HDR,
    BYTE
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FC_W-1:0]    fc_q, fc_d;
  logic [CNT_W-1:0]   ws_q, ws_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               xfer;

  // Byte number idx of a word, counted in transmit order.
  function automatic logic [7:0] pick(
    input logic [DATA_W-1:0] w,
    input logic [IDX_W-1:0]  idx
  );
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (IDX_W'(k) == idx) begin
        if (MSB_FIRST) b = w[DATA_W-1-8*k -: 8];
        else           b = w[8*k +: 8];
      end
    end
    return b;
  endfunction

  assign fifo_rd_en = (state_q == IDLE) && enable
                      && !fifo_empty;
  assign busy       = (state_q != IDLE);
  assign uart_data  = data_q;
  assign uart_valid = valid_q;
  assign words_sent = ws_q;
  assign xfer       = valid_q && uart_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    fc_d    = fc_q;
    ws_d    = ws_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (fifo_rd_en) state_d = LATCH;
      end
      LATCH: begin
        word_d  = fifo_dout;
        idx_d   = '0;
        valid_d = 1'b1;
        // frame_cnt==0 marks the first word of a frame
        if (FRAME_LEN != 0 && fc_q == '0) begin
          state_d = HDR;
          data_d  = HEADER;
        end else begin
          state_d = BYTE;
          data_d  = pick(fifo_dout, '0);
        end
      end
      HDR: begin
        if (xfer) begin
          state_d = BYTE;
          data_d  = pick(word_q, '0);
        end
      end
      BYTE: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ws_d    = ws_q + 1'b1;
            fc_d    = (fc_q == LAST_FC) ? '0
                                        : fc_q + 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = pick(word_q, idx_q + 1'b1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      fc_q    <= '0;
      ws_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      fc_q    <= fc_d;
      ws_q    <= ws_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule
